// File: rtl/regfile_issue_if.sv
// Issue, execute and writeback buses between decoder, issue controller and execute unit.
// The slave modport is the issue controller's view of the buses.
interface regfile_issue_if #(
  parameter int unsigned INDEX_WIDTH = 3,
  parameter int unsigned REG_WIDTH   = 32
);
  logic                   iss_valid;
  logic                   iss_ready;
  logic [INDEX_WIDTH-1:0] iss_rs1;
  logic [INDEX_WIDTH-1:0] iss_rs2;
  logic [INDEX_WIDTH-1:0] iss_rd;
  logic                   iss_wen;

  logic                   ex_valid;
  logic                   ex_ready;
  logic [REG_WIDTH-1:0]   ex_a;
  logic [REG_WIDTH-1:0]   ex_b;
  logic [INDEX_WIDTH-1:0] ex_rd;
  logic                   ex_wen;

  logic                   wb_valid;
  logic [INDEX_WIDTH-1:0] wb_rd;
  logic [REG_WIDTH-1:0]   wb_data;

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
    output iss_ready,
    output ex_valid, ex_a, ex_b, ex_rd, ex_wen,
    input  ex_ready,
    input  wb_valid, wb_rd, wb_data
  );

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
    input  iss_ready,
    input  ex_valid, ex_a, ex_b, ex_rd, ex_wen,
    output ex_ready,
    output wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/regfile_issue_ctrl.sv
// Scoreboarded issue controller: stalls on pending sources/destination, reads operands
// from an external register file and hands them to the execute unit.
module regfile_issue_ctrl #(
  parameter int unsigned INDEX_WIDTH = 3,
  parameter int unsigned REG_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  regfile_issue_if.slave         bus,
  output logic                   rf_we,
  output logic [INDEX_WIDTH-1:0] rf_op0,
  output logic [INDEX_WIDTH-1:0] rf_op1,
  output logic [INDEX_WIDTH-1:0] rf_op2,
  output logic [REG_WIDTH-1:0]   rf_D,
  input  logic [REG_WIDTH-1:0]   rf_S1,
  input  logic [REG_WIDTH-1:0]   rf_S2,
  output logic                   busy
);

  localparam int unsigned NUM_REGS = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, VALID} state_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] rs1;
    logic [INDEX_WIDTH-1:0] rs2;
    logic [INDEX_WIDTH-1:0] rd;
    logic                   wen;
  } issue_t;

  state_t                state;
  state_t                state_nxt;
  issue_t                lat;
  logic [NUM_REGS-1:0]   pend;
  logic [NUM_REGS-1:0]   pend_nxt;
  logic [REG_WIDTH-1:0]  ex_a_q;
  logic [REG_WIDTH-1:0]  ex_b_q;
  logic                  busy_q;
  logic                  clr_rs1;
  logic                  clr_rs2;
  logic                  clr_rd;
  logic                  hazard;
  logic                  accept;

  // Writeback goes straight to the register file and is never stalled.
  assign rf_we  = bus.wb_valid & rstn;
  assign rf_op0 = bus.wb_rd;
  assign rf_D   = bus.wb_data;

  // A writeback retiring this cycle releases its scoreboard bit for the same-cycle check.
  assign clr_rs1 = bus.wb_valid & (bus.wb_rd == bus.iss_rs1);
  assign clr_rs2 = bus.wb_valid & (bus.wb_rd == bus.iss_rs2);
  assign clr_rd  = bus.wb_valid & (bus.wb_rd == bus.iss_rd);

  assign hazard = (pend[bus.iss_rs1] & ~clr_rs1)
                | (pend[bus.iss_rs2] & ~clr_rs2)
                | (bus.iss_wen & pend[bus.iss_rd] & ~clr_rd);

  assign accept = bus.iss_valid & bus.iss_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = VALID;
      VALID:   if (bus.ex_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; operand read indices always follow the latched issue
  always_comb begin
    bus.iss_ready = 1'b0;
    bus.ex_valid  = 1'b0;
    rf_op1        = lat.rs1;
    rf_op2        = lat.rs2;
    unique case (state)
      IDLE:    bus.iss_ready = ~hazard & rstn;
      VALID:   bus.ex_valid  = rstn;
      default: ;
    endcase
  end

  // Scoreboard next value: a same-cycle set for the issued rd overrides a clear.
  always_comb begin
    pend_nxt = pend;
    if (bus.wb_valid)           pend_nxt[bus.wb_rd]  = 1'b0;
    if (accept && bus.iss_wen)  pend_nxt[bus.iss_rd] = 1'b1;
  end

  // Issue latch, operand capture and scoreboard
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lat    <= '0;
      ex_a_q <= '0;
      ex_b_q <= '0;
      pend   <= '0;
      busy_q <= 1'b0;
    end else begin
      pend   <= pend_nxt;
      busy_q <= |pend_nxt;
      if (accept) begin
        lat.rs1 <= bus.iss_rs1;
        lat.rs2 <= bus.iss_rs2;
        lat.rd  <= bus.iss_rd;
        lat.wen <= bus.iss_wen;
      end
      if (state == READ) begin
        ex_a_q <= rf_S1;
        ex_b_q <= rf_S2;
      end
    end
  end

  assign bus.ex_a   = ex_a_q;
  assign bus.ex_b   = ex_b_q;
  assign bus.ex_rd  = lat.rd;
  assign bus.ex_wen = lat.wen;
  assign busy       = busy_q;

endmodule

// File: tb/tb_regfile_issue_ctrl.sv
// Bench for regfile_issue_ctrl: directed scenarios then random traffic, all checked
// against a transaction-level model of scoreboard, register contents and one in-flight op.
module tb_regfile_issue_ctrl;
  localparam int unsigned IW = 3;
  localparam int unsigned RW = 32;
  localparam int unsigned NR = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rf_we;
  logic [IW-1:0] rf_op0, rf_op1, rf_op2;
  logic [RW-1:0] rf_D, rf_S1, rf_S2;
  logic          busy;

  regfile_issue_if #(.INDEX_WIDTH(IW), .REG_WIDTH(RW)) bus ();

  regfile_issue_ctrl #(.INDEX_WIDTH(IW), .REG_WIDTH(RW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus    (bus),
    .rf_we  (rf_we),
    .rf_op0 (rf_op0),
    .rf_op1 (rf_op1),
    .rf_op2 (rf_op2),
    .rf_D   (rf_D),
    .rf_S1  (rf_S1),
    .rf_S2  (rf_S2),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // External register file: write on posedge, read on negedge
  logic [RW-1:0] rf_mem [NR];
  always @(posedge clk) if (rf_we) rf_mem[rf_op0] <= rf_D;
  always @(negedge clk) begin
    rf_S1 <= rf_mem[rf_op1];
    rf_S2 <= rf_mem[rf_op2];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending set, architectural values, at most one op in flight
  bit            m_pend [NR];
  logic [RW-1:0] m_regs [NR];
  bit            m_has;
  int            m_age;
  logic [RW-1:0] m_a, m_b;
  logic [IW-1:0] m_rd;
  bit            m_wen;

  function automatic bit m_busy();
    bit b = 1'b0;
    for (int i = 0; i < NR; i++) b |= m_pend[i];
    return b;
  endfunction

  // One clock cycle: drive, check against model, clock, advance model.
  task automatic step(input bit rv, input bit iv, input logic [IW-1:0] rs1, input logic [IW-1:0] rs2,
                      input logic [IW-1:0] rd, input bit wen, input bit er, input bit wv,
                      input logic [IW-1:0] wrd, input logic [RW-1:0] wd);
    bit hz, exp_rdy, exp_ev;
    rstn = rv;
    bus.iss_valid = iv; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2; bus.iss_rd = rd; bus.iss_wen = wen;
    bus.ex_ready = er;
    bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_data = wd;
    #1;
    hz = (m_pend[rs1] && !(wv && wrd == rs1)) || (m_pend[rs2] && !(wv && wrd == rs2))
      || (wen && m_pend[rd] && !(wv && wrd == rd));
    exp_rdy = rv && !m_has && !hz;
    exp_ev  = rv && m_has && (m_age >= 1);
    chk("iss_ready", 32'(bus.iss_ready), 32'(exp_rdy));
    chk("ex_valid",  32'(bus.ex_valid),  32'(exp_ev));
    chk("busy",      32'(busy),          32'(m_busy()));
    chk("rf_we",     32'(rf_we),         32'(wv && rv));
    if (wv) begin
      chk("rf_op0", 32'(rf_op0), 32'(wrd));
      chk("rf_D",   rf_D,        wd);
    end
    if (exp_ev) begin
      chk("ex_a",   bus.ex_a,          m_a);
      chk("ex_b",   bus.ex_b,          m_b);
      chk("ex_rd",  32'(bus.ex_rd),    32'(m_rd));
      chk("ex_wen", 32'(bus.ex_wen),   32'(m_wen));
    end
    @(posedge clk);
    if (!rv) begin
      m_has = 1'b0;
      for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    end else begin
      if (wv) begin
        m_regs[wrd] = wd;
        m_pend[wrd] = 1'b0;
      end
      if (m_has && m_age >= 1 && er) m_has = 1'b0;
      else if (m_has)                m_age++;
      if (iv && exp_rdy) begin
        m_has = 1'b1; m_age = 0;
        m_a = m_regs[rs1]; m_b = m_regs[rs2]; m_rd = rd; m_wen = wen;
        if (wen) m_pend[rd] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input bit er);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, er, 1'b0, '0, '0);
  endtask

  task automatic wb(input logic [IW-1:0] r, input logic [RW-1:0] d);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, r, d);
  endtask

  task automatic iss(input logic [IW-1:0] rs1, input logic [IW-1:0] rs2, input logic [IW-1:0] rd,
                     input bit wen, input bit er);
    step(1'b1, 1'b1, rs1, rs2, rd, wen, er, 1'b0, '0, '0);
  endtask

  logic [RW-1:0] held_a;

  initial begin
    rstn = 1'b0;
    bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0; bus.iss_wen = 1'b0;
    bus.ex_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    for (int i = 0; i < NR; i++) begin
      rf_mem[i] = '0; m_regs[i] = '0; m_pend[i] = 1'b0;
    end
    m_has = 1'b0; m_age = 0; m_a = '0; m_b = '0; m_rd = '0; m_wen = 1'b0;
    @(posedge clk); #1;

    // Reset state, with a writeback attempt that must be gated
    chk("rst_ex_a", bus.ex_a, 32'h0);
    chk("rst_ex_rd", 32'(bus.ex_rd), 32'h0);
    step(1'b0, 1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3, 32'h99);

    // Basic read of preloaded registers
    wb(3'd3, 32'h11);
    wb(3'd5, 32'h22);
    iss(3'd3, 3'd5, 3'd0, 1'b0, 1'b1);
    idle(1'b1);
    chk("basic_ex_a", bus.ex_a, 32'h11);
    chk("basic_ex_b", bus.ex_b, 32'h22);
    idle(1'b1);

    // RAW stall released by a coincident writeback
    iss(3'd0, 3'd0, 3'd2, 1'b1, 1'b1);
    chk("raw_busy", 32'(busy), 32'h1);
    idle(1'b1); idle(1'b1);
    repeat (3) iss(3'd2, 3'd0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd2, 32'hABCD);
    idle(1'b1);
    chk("raw_ex_a", bus.ex_a, 32'hABCD);
    idle(1'b1);

    // Backpressure hold
    iss(3'd5, 3'd2, 3'd6, 1'b0, 1'b0);
    idle(1'b0);
    held_a = bus.ex_a;
    repeat (5) idle(1'b0);
    chk("hold_ex_a", bus.ex_a, held_a);
    idle(1'b1);
    idle(1'b1);

    // WAW stall and same-cycle set-over-clear
    iss(3'd0, 3'd0, 3'd4, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1);
    iss(3'd0, 3'd0, 3'd4, 1'b1, 1'b1);
    step(1'b1, 1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 1'b1, 1'b1, 3'd4, 32'h44);
    chk("waw_busy", 32'(busy), 32'h1);
    idle(1'b1); idle(1'b1);

    // Reset in VALID aborts the op
    iss(3'd3, 3'd5, 3'd0, 1'b0, 1'b0);
    idle(1'b0);
    chk("abort_pre_valid", 32'(bus.ex_valid), 32'h1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ex_a", bus.ex_a, 32'h0);
    repeat (3) idle(1'b1);

    // Writeback to a non-pending index leaves the scoreboard alone
    iss(3'd0, 3'd0, 3'd1, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1);
    wb(3'd7, 32'h77);
    chk("wb7_busy", 32'(busy), 32'h1);
    wb(3'd1, 32'h1111);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1,
           IW'($urandom), IW'($urandom), IW'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, IW'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_issue_ctrl.md
REGFILE_ISSUE_CTRL -- requirements
Module: regfile_issue_ctrl

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 3, register index width.
REQ-002 SHALL have parameter REG_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports iss_valid input 1, iss_ready output 1; issue handshake from decoder.
REQ-006 SHALL have ports iss_rs1, iss_rs2, iss_rd  input  INDEX_WIDTH each; source and destination indices.
REQ-007 SHALL have port iss_wen  input  1  instruction writes iss_rd.
REQ-008 SHALL have ports ex_valid output 1, ex_ready input 1; operand handshake to execute unit.
REQ-009 SHALL have ports ex_a, ex_b  output  REG_WIDTH; operand values.
REQ-010 SHALL have ports ex_rd output INDEX_WIDTH, ex_wen output 1; forwarded destination info.
REQ-011 SHALL have ports wb_valid input 1, wb_rd input INDEX_WIDTH, wb_data input REG_WIDTH; writeback from execute unit, no backpressure.
REQ-012 SHALL have ports rf_we output 1, rf_op0/rf_op1/rf_op2 output INDEX_WIDTH, rf_D output REG_WIDTH; register file control.
REQ-013 SHALL have ports rf_S1, rf_S2  input  REG_WIDTH; register file read data, sampled by the file on negedge, stable by next posedge.
REQ-014 SHALL have port busy  output  1  any scoreboard bit set.

Function
REQ-015 SHALL drive rf_we = wb_valid & rstn, rf_op0 = wb_rd, rf_D = wb_data combinationally; writeback always accepted.
REQ-016 SHALL keep scoreboard pend[2^INDEX_WIDTH]; clear pend[wb_rd] when wb_valid; set pend[iss_rd] on issue accept with iss_wen; set wins when both target the same index in one cycle.
REQ-017 SHALL compute clr(x) = wb_valid & (wb_rd == x); hazard = (pend[rs1] & !clr(rs1)) | (pend[rs2] & !clr(rs2)) | (iss_wen & pend[rd] & !clr(rd)).
REQ-018 SHALL implement FSM states IDLE, READ, VALID; iss_ready = (state==IDLE) & !hazard & rstn.
REQ-019 IDLE: on iss_valid & iss_ready, latch rs1, rs2, rd, wen; go READ; otherwise stay.
REQ-020 READ: drive rf_op1/rf_op2 from latched rs1/rs2; at the ending posedge capture ex_a <= rf_S1, ex_b <= rf_S2; go VALID.
REQ-021 IDLE and VALID: drive rf_op1/rf_op2 from latched rs1/rs2 (hold last values).
REQ-022 VALID: ex_valid = 1; ex_a, ex_b, ex_rd, ex_wen stable until handshake; on ex_ready go IDLE.
REQ-023 ex_valid SHALL be 0 in IDLE and READ; latency from issue accept at posedge k to ex_valid high is one cycle (ex_valid high after posedge k+1).
REQ-024 Writeback coincident with the accepting cycle SHALL be visible in operands (written at posedge k, read at following negedge); no forwarding path.
REQ-025 SHALL not accept a new issue in the cycle VALID→IDLE handshake completes; earliest re-accept is the following cycle.
REQ-026 busy = OR of all pend bits, registered-state derived (no combinational dependence on wb_valid).
REQ-027 wb_valid to an index with pend=0 SHALL write the register file and leave pend unchanged.

Reset
REQ-028 While rstn=0 at posedge: state=IDLE, pend all 0, ex_a=0, ex_b=0, ex_rd=0, ex_wen=0, latched rs1/rs2/rd=0.
REQ-029 During rstn=0: iss_ready=0, ex_valid=0, rf_we=0, busy=0 after first reset edge.
REQ-030 Reset asserted in READ or VALID SHALL abort the transaction; no ex_valid pulse after reset release until a new issue.

Verification
REQ-031 Preload R3=0x11, R5=0x22 via wb; issue rs1=3, rs2=5, wen=0, ex_ready=1 -> ex_valid one cycle after accept, ex_a=0x11, ex_b=0x22, returns IDLE.
REQ-032 Issue rd=2 wen=1 (pend[2]=1, busy=1); next issue rs1=2 -> iss_ready=0 until wb_valid wb_rd=2 wb_data=0xABCD; accepted that cycle, ex_a=0xABCD.
REQ-033 Hold ex_ready=0 for 5 cycles in VALID -> ex_valid, ex_a, ex_b, ex_rd constant; iss_ready=0; release -> IDLE next cycle.
REQ-034 WAW: pend[4]=1, issue rd=4 wen=1 -> stalls; wb_rd=4 same cycle as issue -> accepted, pend[4] remains 1.
REQ-035 rstn=0 for one posedge during VALID -> ex_valid=0, pend=0, busy=0, ex_a=0 next cycle; no stray handshake after release.
REQ-036 wb_valid wb_rd=7 with pend[7]=0 -> rf_we=1, rf_op0=7, pend unchanged, busy unchanged.
